// File: rtl/wb_pkg.sv
// Shared Wishbone width constants and master FSM state type.
// Slaves on the same bus import these widths too.
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 30;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } wb_mst_state_t;

endpackage

// File: rtl/wb_master_if.sv
// Local command/response port plus pipelined Wishbone bus of wb_master.
// The master modport is the wb_master view; the slave modport is the opposite side.
interface wb_master_if;
    import wb_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [WB_ADDR_W-1:0] cmd_addr;
    logic [WB_DATA_W-1:0] cmd_data;
    logic [WB_SEL_W-1:0]  cmd_sel;

    logic                 rsp_valid;
    logic [WB_DATA_W-1:0] rsp_data;
    logic                 rsp_err;
    logic                 rsp_timeout;

    logic                 wb_cyc;
    logic                 wb_stb;
    logic                 wb_we;
    logic [WB_ADDR_W-1:0] wb_addr;
    logic [WB_DATA_W-1:0] wb_wdata;
    logic [WB_SEL_W-1:0]  wb_sel;
    logic                 wb_stall;
    logic                 wb_ack;
    logic                 wb_err;
    logic [WB_DATA_W-1:0] wb_rdata;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_err, rsp_timeout,
        output wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
        input  wb_stall, wb_ack, wb_err, wb_rdata
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_err, rsp_timeout,
        input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
        output wb_stall, wb_ack, wb_err, wb_rdata
    );

endinterface

// File: rtl/wb_master.sv
// Single-outstanding pipelined Wishbone master: one local command becomes one bus cycle,
// answered by a one-cycle response strobe; a watchdog aborts unanswered cycles.
module wb_master
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    wb_master_if.master bus
);

    wb_mst_state_t        state_q;
    logic                 ready_q;
    logic                 cyc_q;
    logic                 stb_q;
    logic                 we_q;
    logic [WB_ADDR_W-1:0] addr_q;
    logic [WB_DATA_W-1:0] data_q;
    logic [WB_SEL_W-1:0]  sel_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic                 rsp_timeout_q;
    logic [WB_DATA_W-1:0] rsp_data_q;

    logic accept;
    logic busy;
    logic done;
    logic timeout_hit;

    assign accept = bus.cmd_valid & ready_q;
    assign busy   = (state_q != IDLE);
    // ack/err only count while the cycle is open; late answers are ignored
    assign done   = busy & (bus.wb_ack | bus.wb_err);

    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
        logic [CntW-1:0] cnt_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= '0;
            end else if (busy && !timeout_hit) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end

        assign timeout_hit = busy && (cnt_q == CntW'(TIMEOUT_CYCLES));
    end else begin : g_no_wdog
        assign timeout_hit = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            sel_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        state_q <= REQ;
                        ready_q <= 1'b0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= bus.cmd_we;
                        addr_q  <= bus.cmd_addr;
                        data_q  <= bus.cmd_data;
                        sel_q   <= bus.cmd_sel;
                    end
                end
                REQ, WAIT: begin
                    // Completion wins over stall so a registered stall+ack slave is not re-strobed
                    if (done) begin
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.wb_err;
                        rsp_data_q  <= (bus.wb_err || we_q) ? '0 : bus.wb_rdata;
                    end else if (timeout_hit) begin
                        state_q       <= IDLE;
                        ready_q       <= 1'b1;
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else if (state_q == REQ && !bus.wb_stall) begin
                        state_q <= WAIT;
                        stb_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = ready_q;
    assign bus.wb_cyc      = cyc_q;
    assign bus.wb_stb      = stb_q;
    assign bus.wb_we       = we_q;
    assign bus.wb_addr     = addr_q;
    assign bus.wb_wdata    = data_q;
    assign bus.wb_sel      = sel_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_wb_master.sv
// Directed and randomized bench for wb_master with a scripted Wishbone slave
// and a latency/data reference model derived from the bus-cycle rules.
module tb_wb_master;

    localparam int T = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];

    wb_master_if bus ();

    wb_master #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic clear_wb();
        bus.wb_stall = 1'b0;
        bus.wb_ack   = 1'b0;
        bus.wb_err   = 1'b0;
        bus.wb_rdata = '0;
    endtask

    // kind: 0 = ack, 1 = err, 2 = ack+err. resp_at < 0 means the slave never answers.
    // Slave raises stall for the first stall_n cycles of the bus cycle.
    task automatic run_txn(input string tag, input logic we, input logic [29:0] addr,
                           input logic [31:0] data, input logic [3:0] sel,
                           input int stall_n, input int resp_at, input int kind);
        int          exp_done;
        bit          exp_to;
        int          got_k;
        int          stb_n;
        int          cyc_n;
        logic [31:0] exp_data;
        logic [31:0] got_data;
        logic        got_err;
        logic        got_to;
        logic        got_rdy;
        bit          respond;

        exp_to   = !(resp_at >= 0 && resp_at <= T);
        exp_done = exp_to ? T : resp_at;
        exp_data = (!we && !exp_to && kind == 0) ? ref_mem[addr[3:0]] : 32'h0;

        chk({tag, ".ready"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        bus.cmd_sel   = sel;
        clear_wb();
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = $urandom;

        got_k = -1;
        stb_n = 0;
        cyc_n = 0;
        got_data = 'x;
        got_err = 1'bx;
        got_to = 1'bx;
        got_rdy = 1'bx;
        for (int k = 0; k < T + 6; k++) begin
            if (bus.rsp_valid) begin
                got_k    = k;
                got_data = bus.rsp_data;
                got_err  = bus.rsp_err;
                got_to   = bus.rsp_timeout;
                got_rdy  = bus.cmd_ready;
                break;
            end
            if (bus.wb_cyc) cyc_n++;
            if (bus.wb_stb) begin
                stb_n++;
                chk({tag, ".fields"}, {bus.wb_we, bus.wb_addr, bus.wb_wdata, bus.wb_sel},
                    {we, addr, data, sel});
            end
            respond      = (k == resp_at);
            bus.wb_stall = (k < stall_n);
            bus.wb_ack   = respond && kind != 1;
            bus.wb_err   = respond && kind != 0;
            bus.wb_rdata = respond ? slv_mem[addr[3:0]] : $urandom;
            if (respond && kind == 0 && bus.wb_cyc && bus.wb_we)
                slv_mem[bus.wb_addr[3:0]] = merge(slv_mem[bus.wb_addr[3:0]], bus.wb_wdata,
                                                  bus.wb_sel);
            tick();
        end
        clear_wb();

        if (!exp_to && kind == 0 && we) ref_mem[addr[3:0]] = merge(ref_mem[addr[3:0]], data, sel);

        chk({tag, ".latency"}, got_k, exp_done + 1);
        chk({tag, ".stb_cycles"}, stb_n, ((stall_n < exp_done) ? stall_n : exp_done) + 1);
        chk({tag, ".cyc_cycles"}, cyc_n, exp_done + 1);
        chk({tag, ".rsp_err"}, got_err, (exp_to || kind != 0) ? 1 : 0);
        chk({tag, ".rsp_timeout"}, got_to, exp_to ? 1 : 0);
        chk({tag, ".rsp_data"}, got_data, exp_data);
        chk({tag, ".ready_at_rsp"}, got_rdy, 1);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_sel   = '0;
        clear_wb();
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = 32'(i);
            ref_mem[i] = 32'(i);
        end

        // Reset state
        #12;
        chk("reset.outputs", {bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_addr, bus.wb_wdata,
            bus.wb_sel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("reset.ready", bus.cmd_ready, 1);
        chk("reset.idle_rsp", bus.rsp_valid, 0);

        // Zero-stall read, then stalled write, then read-back
        run_txn("rd3", 1'b0, 30'h3, 32'hDEAD_BEEF, 4'hF, 0, 1, 0);
        run_txn("wr5", 1'b1, 30'h5, 32'h0000_ABCD, 4'hF, 3, 4, 0);
        chk("wr5.slave_mem", slv_mem[5], 32'h0000_ABCD);
        run_txn("rd5", 1'b0, 30'h5, 32'h0, 4'hF, 0, 1, 0);

        // Registered-stall slave: stall and ack rise together, back-to-back reads
        for (int i = 0; i < 4; i++) run_txn("b2b", 1'b0, 30'(i + 2), 32'h0, 4'hF, 2, 1, 0);
        // Stall in first cycle, stall drops together with ack
        run_txn("stall_ack", 1'b0, 30'h9, 32'h0, 4'hF, 1, 1, 0);
        tick();
        chk("single_strobe", bus.rsp_valid, 0);

        // Slave error on a write, and ack+err together on a read
        run_txn("wr_err", 1'b1, 30'h7, 32'h1234_5678, 4'h3, 0, 1, 1);
        run_txn("rd_ackerr", 1'b0, 30'h4, 32'h0, 4'hF, 0, 2, 2);

        // Watchdog timeout, then a late ack that must be ignored
        run_txn("timeout", 1'b0, 30'h6, 32'h0, 4'hF, 0, -1, 0);
        bus.wb_ack   = 1'b1;
        bus.wb_rdata = 32'hFFFF_FFFF;
        tick();
        clear_wb();
        chk("late_ack.rsp", bus.rsp_valid, 0);
        chk("late_ack.cyc", bus.wb_cyc, 0);
        tick();
        chk("late_ack.rsp2", bus.rsp_valid, 0);
        run_txn("after_to", 1'b0, 30'h6, 32'h0, 4'hF, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int          st;
            int          ra;
            int          r;
            int          kd;
            logic [29:0] a;
            st = int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 9));
            if (r == 0) ra = -1;
            else if (r == 1) ra = int'($urandom_range(T + 1, T + 3));
            else ra = int'($urandom_range(0, st + 3));
            r  = int'($urandom_range(0, 5));
            kd = (r < 4) ? 0 : r - 3;
            a  = 30'($urandom);
            run_txn("rand", 1'($urandom), a, $urandom, 4'($urandom_range(1, 15)), st, ra, kd);
        end
        for (int i = 0; i < 16; i++) chk("rand.mem", slv_mem[i], ref_mem[i]);

        // Reset during WAIT abandons the cycle without a response
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 30'h2;
        bus.cmd_sel   = 4'hF;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("rst_wait.in_wait", {bus.wb_cyc, bus.wb_stb}, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wait.outputs", {bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_addr, bus.wb_wdata,
            bus.wb_sel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_data}, 0);
        bus.wb_ack = 1'b1;
        tick();
        clear_wb();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_wait.ready", bus.cmd_ready, 1);
        chk("rst_wait.no_rsp", {bus.rsp_valid, bus.wb_cyc}, 0);
        run_txn("after_rst", 1'b0, 30'h3, 32'h0, 4'hF, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
